// File: rtl/mat_pkg.sv
// mat_pkg
// Shared definitions for the row-addressed complex-matrix store:
//   SIZE, WIDTH - default matrix dimension and bits per real/imag part
//   row_t       - one matrix row, element k = {imag, real} at [k*2W +: 2W]
//   addr_t      - row/column index
//   state_t     - server FSM states
package mat_pkg;

    localparam int SIZE   = 4;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = $clog2(SIZE);

    typedef logic [SIZE-1:0][2*WIDTH-1:0] row_t;
    typedef logic [ADDR_W-1:0]            addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

endpackage

// File: rtl/mat_row_server_if.sv
// mat_row_server_if
// Engine-side row bus between an lu / triang_matrix_inv engine (master)
// and the matrix store (slave).
//   rd_addr, rd_addr_valid             engine read request
//   mat_row, mat_row_addr, mat_row_valid  registered row returned one cycle later
//   wr_row, wr_addr, wr_valid          engine row write-back
//   wr_ready                           store accepts write-back (SERVE only)
interface mat_row_server_if #(
    parameter int SIZE  = mat_pkg::SIZE,
    parameter int WIDTH = mat_pkg::WIDTH
);

    logic [$clog2(SIZE)-1:0]      rd_addr;
    logic                         rd_addr_valid;
    logic [SIZE-1:0][2*WIDTH-1:0] mat_row;
    logic [$clog2(SIZE)-1:0]      mat_row_addr;
    logic                         mat_row_valid;
    logic [SIZE-1:0][2*WIDTH-1:0] wr_row;
    logic [$clog2(SIZE)-1:0]      wr_addr;
    logic                         wr_valid;
    logic                         wr_ready;

    modport master (
        output rd_addr, rd_addr_valid, wr_row, wr_addr, wr_valid,
        input  mat_row, mat_row_addr, mat_row_valid, wr_ready
    );

    modport slave (
        input  rd_addr, rd_addr_valid, wr_row, wr_addr, wr_valid,
        output mat_row, mat_row_addr, mat_row_valid, wr_ready
    );

endinterface

// File: rtl/mat_row_server_row_transpose.sv
// row_transpose
// Combinational column extraction used by the transposed dump.
//   rows_i - full matrix, rows_i[k] is row k
//   col_i  - column index to extract
//   row_o  - element k = element col_i of row k
module row_transpose #(
    parameter int SIZE  = mat_pkg::SIZE,
    parameter int WIDTH = mat_pkg::WIDTH
) (
    input  logic [SIZE-1:0][SIZE-1:0][2*WIDTH-1:0] rows_i,
    input  logic [$clog2(SIZE)-1:0]                col_i,
    output logic [SIZE-1:0][2*WIDTH-1:0]           row_o
);

    always_comb begin
        row_o = '0;
        for (int k = 0; k < SIZE; k++) begin
            row_o[k] = rows_i[k][col_i];
        end
    end

endmodule

// File: rtl/mat_row_server.sv
// mat_row_server
// Row-addressed complex-matrix store. A host loads it row by row, an engine
// then reads/writes rows over the eng bus, and the host drains it row-major
// or transposed.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  synchronous abort to IDLE (memory kept)
//   cmd_load/serve/dump_i    command pulses, sampled in IDLE (load > serve > dump)
//   dump_transpose_i         latched with cmd_dump_i
//   cmd_done_i               ends SERVE
//   load_row_i/valid/ready   host load stream
//   dump_row/addr/valid/ready host drain stream
//   busy_o                   state != IDLE
//   eng                      engine row bus (slave side)
module mat_row_server #(
    parameter int SIZE  = mat_pkg::SIZE,
    parameter int WIDTH = mat_pkg::WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         cmd_load_i,
    input  logic                         cmd_serve_i,
    input  logic                         cmd_dump_i,
    input  logic                         dump_transpose_i,
    input  logic                         cmd_done_i,
    input  logic [SIZE-1:0][2*WIDTH-1:0] load_row_i,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    output logic [SIZE-1:0][2*WIDTH-1:0] dump_row_o,
    output logic [$clog2(SIZE)-1:0]      dump_addr_o,
    output logic                         dump_valid_o,
    input  logic                         dump_ready_i,
    output logic                         busy_o,
    mat_row_server_if.slave              eng
);

    import mat_pkg::*;

    localparam int AW = $clog2(SIZE);

    state_t                                 state_q, state_d;
    logic [AW-1:0]                          cnt_q, cnt_d;
    logic                                   transpose_q, transpose_d;
    logic [SIZE-1:0][SIZE-1:0][2*WIDTH-1:0] mem_q;
    logic [SIZE-1:0][2*WIDTH-1:0]           col_row;

    logic [SIZE-1:0][2*WIDTH-1:0] rd_row_p1;
    logic [AW-1:0]                rd_addr_p1;
    logic                         vld_p1;

    logic load_fire, dump_fire, rd_fire, wr_fire, cnt_last;

    // flush_i masks every handshake in its cycle
    assign load_fire = (state_q == ST_LOAD)  && load_valid_i      && !flush_i;
    assign dump_fire = (state_q == ST_DUMP)  && dump_ready_i      && !flush_i;
    assign rd_fire   = (state_q == ST_SERVE) && eng.rd_addr_valid && !flush_i;
    assign wr_fire   = (state_q == ST_SERVE) && eng.wr_valid      && !flush_i;
    assign cnt_last  = (cnt_q == AW'(SIZE - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            transpose_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            transpose_q <= transpose_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        transpose_d = transpose_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (cmd_load_i) begin
                        state_d = ST_LOAD;
                    end else if (cmd_serve_i) begin
                        state_d = ST_SERVE;
                    end else if (cmd_dump_i) begin
                        state_d     = ST_DUMP;
                        transpose_d = dump_transpose_i;
                    end
                end
                ST_LOAD: begin
                    // counter wraps to 0 on the last beat (SIZE is a power of two)
                    if (load_fire) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_last) state_d = ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (cmd_done_i) state_d = ST_IDLE;
                end
                ST_DUMP: begin
                    if (dump_fire) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_last) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    row_transpose #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_row_transpose (
        .rows_i (mem_q),
        .col_i  (cnt_q),
        .row_o  (col_row)
    );

    // Dump data is a pure function of state/cnt/memory; memory is frozen in
    // DUMP, so the row stays stable while the host stalls.
    always_comb begin
        load_ready_o = (state_q == ST_LOAD);
        eng.wr_ready = (state_q == ST_SERVE);
        dump_valid_o = (state_q == ST_DUMP);
        busy_o       = (state_q != ST_IDLE);
        dump_addr_o  = '0;
        dump_row_o   = '0;
        if (state_q == ST_DUMP) begin
            dump_addr_o = cnt_q;
            dump_row_o  = transpose_q ? col_row : mem_q[cnt_q];
        end
    end

    // Stage p0 -> p1: row read registered, memory written on the same edge,
    // so a colliding read captures the old row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '0;
            rd_row_p1  <= '0;
            rd_addr_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire) begin
                rd_row_p1  <= mem_q[eng.rd_addr];
                rd_addr_p1 <= eng.rd_addr;
            end
            if (load_fire) mem_q[cnt_q]       <= load_row_i;
            if (wr_fire)   mem_q[eng.wr_addr] <= eng.wr_row;
        end
    end

    assign eng.mat_row       = rd_row_p1;
    assign eng.mat_row_addr  = rd_addr_p1;
    assign eng.mat_row_valid = vld_p1;

endmodule

// File: tb/tb_mat_row_server.sv
module tb_mat_row_server;

    import mat_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_ni;
    logic  flush_i, cmd_load_i, cmd_serve_i, cmd_dump_i, dump_transpose_i, cmd_done_i;
    row_t  load_row_i;
    logic  load_valid_i, load_ready_o;
    row_t  dump_row_o;
    addr_t dump_addr_o;
    logic  dump_valid_o, dump_ready_i, busy_o;

    mat_row_server_if #(.SIZE(SIZE), .WIDTH(WIDTH)) eng ();

    mat_row_server #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .cmd_load_i       (cmd_load_i),
        .cmd_serve_i      (cmd_serve_i),
        .cmd_dump_i       (cmd_dump_i),
        .dump_transpose_i (dump_transpose_i),
        .cmd_done_i       (cmd_done_i),
        .load_row_i       (load_row_i),
        .load_valid_i     (load_valid_i),
        .load_ready_o     (load_ready_o),
        .dump_row_o       (dump_row_o),
        .dump_addr_o      (dump_addr_o),
        .dump_valid_o     (dump_valid_o),
        .dump_ready_i     (dump_ready_i),
        .busy_o           (busy_o),
        .eng              (eng)
    );

    always #5 clk_i = ~clk_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    row_t exp_mem [SIZE];
    row_t row5;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // element (r,c) = {imag = -(10r+c), real = 10r+c} as doubles
    function automatic logic [127:0] el(int r, int c);
        real v;
        v = 10.0 * r + c;
        return {$realtobits(-v), $realtobits(v)};
    endfunction

    function automatic row_t mkrow(int r);
        row_t x;
        for (int c = 0; c < SIZE; c++) x[c] = el(r, c);
        return x;
    endfunction

    function automatic row_t tr_row(int j);
        row_t x;
        for (int k = 0; k < SIZE; k++) x[k] = exp_mem[k][j];
        return x;
    endfunction

    task automatic dump_row_major(input string tag);
        dump_transpose_i = 1'b0;
        cmd_dump_i = 1'b1;
        tick();
        cmd_dump_i   = 1'b0;
        dump_ready_i = 1'b1;
        for (int j = 0; j < SIZE; j++) begin
            check({tag, "_valid"}, dump_valid_o, 1);
            check({tag, "_addr"}, dump_addr_o, j);
            check({tag, "_row"}, dump_row_o, exp_mem[j]);
            tick();
        end
        dump_ready_i = 1'b0;
        check({tag, "_end_busy"}, busy_o, 0);
    endtask

    initial begin
        int   pat [4] = '{1, 0, 0, 1};
        int   beat;
        logic rdy, last_rdy;
        row_t prev_row;

        rst_ni = 1'b0;
        {flush_i, cmd_load_i, cmd_serve_i, cmd_dump_i, dump_transpose_i, cmd_done_i} = '0;
        load_row_i = '0; load_valid_i = 1'b0; dump_ready_i = 1'b0;
        eng.rd_addr = '0; eng.rd_addr_valid = 1'b0;
        eng.wr_row = '0; eng.wr_addr = '0; eng.wr_valid = 1'b0;
        for (int c = 0; c < SIZE; c++) row5[c] = {64'h0, 64'h4014000000000000};

        // reset state
        repeat (2) tick();
        check("rst_busy", busy_o, 0);
        check("rst_load_ready", load_ready_o, 0);
        check("rst_wr_ready", eng.wr_ready, 0);
        check("rst_dump_valid", dump_valid_o, 0);
        check("rst_mat_valid", eng.mat_row_valid, 0);
        check("rst_dump_row", dump_row_o, 0);
        check("rst_mat_row", eng.mat_row, 0);
        rst_ni = 1'b1;
        tick();

        // load 4 rows
        cmd_load_i = 1'b1;
        tick();
        cmd_load_i = 1'b0;
        check("load_ready", load_ready_o, 1);
        check("load_busy", busy_o, 1);
        for (int r = 0; r < SIZE; r++) begin
            load_row_i   = mkrow(r);
            load_valid_i = 1'b1;
            exp_mem[r]   = mkrow(r);
            tick();
        end
        load_valid_i = 1'b0;
        check("load_end_ready", load_ready_o, 0);
        check("load_end_busy", busy_o, 0);

        // row-major dump, plus a literal check of row 2 element 1
        dump_transpose_i = 1'b0;
        cmd_dump_i = 1'b1;
        tick();
        cmd_dump_i   = 1'b0;
        dump_ready_i = 1'b1;
        for (int j = 0; j < SIZE; j++) begin
            check("rm_valid", dump_valid_o, 1);
            check("rm_addr", dump_addr_o, j);
            check("rm_row", dump_row_o, exp_mem[j]);
            if (j == 2) check("rm_r2e1", dump_row_o[1], {64'hC035000000000000, 64'h4035000000000000});
            tick();
        end
        dump_ready_i = 1'b0;
        check("rm_end_valid", dump_valid_o, 0);
        check("rm_end_busy", busy_o, 0);

        // serve: read latency
        cmd_serve_i = 1'b1;
        tick();
        cmd_serve_i = 1'b0;
        check("srv_wr_ready", eng.wr_ready, 1);
        check("srv_idle_valid", eng.mat_row_valid, 0);
        eng.rd_addr = 2'd3; eng.rd_addr_valid = 1'b1;
        tick();
        eng.rd_addr_valid = 1'b0;
        check("rd3_valid", eng.mat_row_valid, 1);
        check("rd3_addr", eng.mat_row_addr, 3);
        check("rd3_row", eng.mat_row, exp_mem[3]);
        tick();
        check("rd3_one_cycle", eng.mat_row_valid, 0);

        // read/write collision on row 1
        eng.rd_addr = 2'd1; eng.rd_addr_valid = 1'b1;
        eng.wr_addr = 2'd1; eng.wr_row = row5; eng.wr_valid = 1'b1;
        tick();
        eng.rd_addr_valid = 1'b0; eng.wr_valid = 1'b0;
        check("coll_old_row", eng.mat_row, exp_mem[1]);
        check("coll_old_e1", eng.mat_row[1][63:0], 64'h4026000000000000);
        exp_mem[1] = row5;
        eng.rd_addr_valid = 1'b1;
        tick();
        eng.rd_addr_valid = 1'b0;
        check("coll_new_row", eng.mat_row, row5);
        check("coll_new_e1", eng.mat_row[1][63:0], 64'h4014000000000000);

        // read issued with cmd_done is still answered
        eng.rd_addr = 2'd0; eng.rd_addr_valid = 1'b1; cmd_done_i = 1'b1;
        tick();
        eng.rd_addr_valid = 1'b0; cmd_done_i = 1'b0;
        check("done_rd_valid", eng.mat_row_valid, 1);
        check("done_rd_row", eng.mat_row, exp_mem[0]);
        check("done_busy", busy_o, 0);
        check("done_wr_ready", eng.wr_ready, 0);

        // transposed dump with ready 1,0,0,1 then held
        dump_transpose_i = 1'b1;
        cmd_dump_i = 1'b1;
        tick();
        cmd_dump_i = 1'b0;
        dump_transpose_i = 1'b0;
        beat = 0;
        last_rdy = 1'b1;
        prev_row = '0;
        for (int cyc = 0; cyc < 20 && busy_o; cyc++) begin
            rdy = (cyc < 4) ? pat[cyc][0] : 1'b1;
            check("tr_valid", dump_valid_o, 1);
            check("tr_addr", dump_addr_o, beat);
            check("tr_row", dump_row_o, tr_row(beat));
            if (cyc > 0 && !last_rdy) check("tr_stall_stable", dump_row_o, prev_row);
            prev_row     = dump_row_o;
            last_rdy     = rdy;
            dump_ready_i = rdy;
            tick();
            if (rdy) beat++;
        end
        dump_ready_i = 1'b0;
        check("tr_beats", beat, SIZE);
        check("tr_end_busy", busy_o, 0);

        // flush after two load beats; flush beats the concurrent load beat
        cmd_load_i = 1'b1;
        tick();
        cmd_load_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            load_row_i = mkrow(r + 5); load_valid_i = 1'b1;
            exp_mem[r] = mkrow(r + 5);
            tick();
        end
        load_row_i = mkrow(9); flush_i = 1'b1;
        tick();
        flush_i = 1'b0; load_valid_i = 1'b0;
        check("flush_busy", busy_o, 0);
        check("flush_load_ready", load_ready_o, 0);
        eng.rd_addr = 2'd2; eng.rd_addr_valid = 1'b1;
        tick();
        eng.rd_addr_valid = 1'b0;
        check("idle_rd_dropped", eng.mat_row_valid, 0);
        dump_row_major("fl");

        // asynchronous reset in the middle of DUMP
        cmd_dump_i = 1'b1;
        tick();
        cmd_dump_i = 1'b0;
        check("ar_pre_valid", dump_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("ar_valid", dump_valid_o, 0);
        check("ar_row", dump_row_o, 0);
        check("ar_busy", busy_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        for (int r = 0; r < SIZE; r++) exp_mem[r] = '0;
        dump_row_major("ar");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_row_server.md
# mat_row_server

Row-addressed complex-matrix store that responds to the row-read / row-write protocol driven by the `lu` and `triang_matrix_inv` engines. It replaces the behavioural row memory with synthesizable RTL. A host fills it row by row, then lets an engine run against it: the engine issues read addresses, receives registered rows, and writes rows back. The host then drains the store, either row-major or transposed. This lets the LU → triangular-inverse → Schur-update chain run without testbench glue.

## Interface
- `SIZE`, 4, matrix dimension; power of two, ≥2
- `WIDTH`, 64, bits per real/imag part (IEEE double)
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset: one clock; reset is asynchronous and active-low
- `flush_i`  in  1  synchronous abort to IDLE
- `cmd_load_i`, `cmd_serve_i`, `cmd_dump_i`  in  1 each  command pulses, sampled in IDLE only
- `dump_transpose_i`  in  1  latched with `cmd_dump_i`
- `cmd_done_i`  in  1  ends SERVE
- `load_row_i`  in  SIZE×2·WIDTH  host row, element k = {imag,real} at bits [k·2W +: 2W]
- `load_valid_i` / `load_ready_o`  in/out  1  load handshake
- `dump_row_o`  out  SIZE×2·WIDTH  drained row or column
- `dump_addr_o`  out  clog2(SIZE)  index of the drained row
- `dump_valid_o` / `dump_ready_i`  out/in  1  dump handshake
- `rd_addr_i`  in  clog2(SIZE)  engine read address
- `rd_addr_valid_i`  in  1  engine read request
- `mat_row_o`  out  SIZE×2·WIDTH  returned row
- `mat_row_addr_o`  out  clog2(SIZE)  echoed read address
- `mat_row_valid_o`  out  1  returned row valid
- `wr_row_i`, `wr_addr_i`, `wr_valid_i`  in  engine write-back
- `wr_ready_o`  out  1  write accept
- `busy_o`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, SERVE, DUMP. Memory is SIZE rows × SIZE·2·WIDTH bits.
- IDLE accepts commands. Priority when several arrive in the same cycle: load > serve > dump. Commands outside IDLE are ignored.
- **LOAD**
  - `load_ready_o` = 1.
  - Each accepted beat writes `mem[cnt]`; `cnt` increments.
  - The beat accepted with `cnt` = SIZE−1 returns the FSM to IDLE.
- **SERVE**
  - `wr_ready_o` = 1.
  - A read request at edge t is answered at t+1: `mat_row_o` = `mem[addr]`, `mat_row_addr_o` = addr, `mat_row_valid_o` high for one cycle.
  - The read side has no backpressure.
  - A write updates `mem[wr_addr_i]` at the edge.
  - Read and write to the same address in the same cycle: the read returns the old contents.
  - `cmd_done_i` → IDLE. A read requested in the same cycle as `cmd_done_i` is still answered.
- **DUMP**
  - `cnt` counts 0..SIZE−1.
  - Row-major mode: `dump_row_o` = `mem[cnt]`.
  - Transposed mode: element k of `dump_row_o` = element `cnt` of `mem[k]`.
  - `dump_addr_o` = `cnt`.
  - `dump_valid_o` is held, with stable data, until `dump_ready_i`.
  - The last accepted beat → IDLE.
- Outside SERVE, read requests are dropped and `wr_ready_o` = 0.
- `flush_i`: next state IDLE, `cnt` = 0, all valid/ready outputs low next cycle. Memory contents are preserved.

## Timing
- Reset values:
  - every output 0, state IDLE, `cnt` 0
  - memory all-zero
  - `dump_row_o` / `mat_row_o` data 0
- Reset mid-operation aborts immediately.
- Latencies:
  - command accepted at edge t → new state effective at t+1
  - `load_ready_o` / `wr_ready_o` / `dump_valid_o` asserted from t+1
  - read latency is exactly 1 cycle
  - dump row is valid from the first DUMP cycle, with no bubble between accepted beats
- Throughput:
  - full load takes SIZE cycles with `load_valid_i` held
  - full dump takes SIZE cycles with `dump_ready_i` held
- `busy_o` is combinational from state.
- `flush_i` has priority over every command and handshake in the same cycle.

## Structure
- Shared package `mat_pkg`:
  - `SIZE`, `WIDTH` defaults
  - row type (`logic [SIZE-1:0][2*WIDTH-1:0]`)
  - address type
  - FSM state enum
- One natural sub-module, `row_transpose`: combinational column extraction for dump. Everything else lives in the top module.

## Test plan
- **Load/dump round trip:** load rows whose elements encode value 10·r+c (real) and −(10·r+c) (imag), then row-major dump → `dump_addr_o` 0..3 in order; row 2 element 1 = {−21.0, 21.0}.
- **Read latency:** in SERVE, `rd_addr_i`=3 with valid at edge t → `mat_row_valid_o`=1, `mat_row_addr_o`=3, and the correct row, at t+1 only.
- **Read/write collision:** same-cycle write of row 1 with value 5.0 and read of row 1 → returns the old 11.0. The next read of row 1 returns 5.0.
- **Transposed dump with backpressure:** `dump_ready_i` toggles 1,0,0,1 → element k of beat j = original (k,j); data stable while stalled; 4 beats total.
- **Flush and inactive-state drop:** `flush_i` after 2 load beats → IDLE next cycle, rows 0–1 retained, `cnt` cleared; a read request while in IDLE produces no `mat_row_valid_o`.
- **Asynchronous reset mid-DUMP:** reset asserted during DUMP → all outputs 0 without waiting for a clock edge; a subsequent dump reads zeros.
